led_framebuffer: RTL
====================

Name: led_framebuffer

Overview:
- Double-buffered pixel store feeding the 16x32 LED panel scan driver directly upstream of it.
- A producer writes single pixels into the back bank.
- The scan driver reads the front bank one column at a time and gets the top-half and bottom-half colours for the current row address together.
- The bank swap is deferred to a frame boundary, so the panel never shows a half-written frame.

Parameters:
- COLOR_DEPTH, 2, bits per colour channel; must match the scan driver's depth.
- COLUMNS_BITS, 5, column index width (32 columns).
- ADDRESS_BITS, 3, row address width (8 scan addresses; the panel has 2^(ADDRESS_BITS+1) rows).

Ports:
- CLOCK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- WR_VALID  in  1  producer has a pixel write
- WR_READY  out  1  block accepts a write this cycle
- WR_X  in  COLUMNS_BITS  pixel column
- WR_Y  in  ADDRESS_BITS+1  pixel row; MSB selects the half (0 = top/RGB_0, 1 = bottom/RGB_1)
- WR_RGB  in  3*COLOR_DEPTH  {b,g,r}, each COLOR_DEPTH wide
- CLEAR  in  1  pulse: zero the whole back bank
- SWAP_REQ  in  1  pulse: make the back bank the front bank at the next frame boundary
- SWAP_DONE  out  1  one-cycle pulse when the swap has taken effect
- FRAME_START  in  1  pulse from the scan driver, one cycle before the first read of a frame
- RD_EN  in  1  read request
- RD_ADDRESS  in  ADDRESS_BITS  row address to read
- RD_COLUMN  in  COLUMNS_BITS  column to read
- RD_VALID  out  1  RD_RGB_0/1 are valid
- RD_RGB_0  out  3*COLOR_DEPTH  top-half pixel {b,g,r}
- RD_RGB_1  out  3*COLOR_DEPTH  bottom-half pixel {b,g,r}
- BUSY  out  1  a clear or swap is in progress

Behaviour:
- Reset values: state S_IDLE, front bank = 0, WR_READY=1, SWAP_DONE=0, RD_VALID=0, RD_RGB_0/1=0, BUSY=0.
- RAM contents are not reset.
- Reset asserted mid-clear aborts the clear; the back bank is then partially cleared and the state returns to S_IDLE.
- Storage: two RAMs, one per half. Word index = {bank, address, column}. Word width = 3*COLOR_DEPTH.
- Write:
  - A write is accepted when WR_VALID & WR_READY.
  - It goes to the back bank (~front), RAM WR_Y[MSB], word {~front, WR_Y[ADDRESS_BITS-1:0], WR_X}.
  - WR_READY = (state == S_IDLE) & ~CLEAR & ~SWAP_REQ, i.e. the request-cycle pulse also drops ready.
- Read:
  - RD_EN in cycle N reads both RAMs at {front, RD_ADDRESS, RD_COLUMN}.
  - RD_RGB_0/1 and RD_VALID=1 appear in cycle N+1.
  - RD_VALID=0 in any cycle following RD_EN=0.
  - RD_RGB_0/1 hold their last value when no read is issued.
  - Reads are never stalled and are legal in every state.
- States:
  - S_IDLE:
    - CLEAR -> S_CLEAR, clear counter = 0.
    - Else SWAP_REQ -> S_SWAP_WAIT.
    - CLEAR and SWAP_REQ in the same cycle: CLEAR wins and SWAP_REQ is dropped.
  - S_CLEAR:
    - Each cycle writes 0 to both RAMs at {~front, counter}, then increments the counter.
    - The counter is ADDRESS_BITS+COLUMNS_BITS wide.
    - On counter all-ones (the 256th write by default) -> S_IDLE.
    - CLEAR/SWAP_REQ are ignored in this state.
  - S_SWAP_WAIT:
    - On FRAME_START, toggle front, pulse SWAP_DONE the next cycle, -> S_IDLE.
    - CLEAR/SWAP_REQ are ignored.
- A read issued in the same cycle as the swapping FRAME_START uses the old front bank; reads from the following cycle use the new one.
- FRAME_START in S_IDLE or S_CLEAR has no effect.
- BUSY = (state != S_IDLE).
- No producer writes are lost: writes are only accepted in S_IDLE.

Decomposition:
- Shared include led_panel_defs.vh holds:
  - panel geometry localparams (PANEL_COLUMNS=32, PANEL_ADDRESSES=8, PANEL_ROWS=16);
  - default COLOR_DEPTH;
  - {b,g,r} field offsets, also used by the scan driver.
- One sub-module: led_framebuffer_ram.
  - Simple dual-port, one write port and one registered read port, parameterised depth/width.
  - Instantiated twice (top half, bottom half); written so that yosys infers iCE40 BRAM.

Test Plan:
- Reset, CLEAR, wait for BUSY=0 (exactly 256 cycles after the CLEAR cycle), SWAP_REQ, FRAME_START; read all 8x32 locations -> every RD_RGB_0/1 = 0, RD_VALID one cycle after each RD_EN.
- Write (x=5,y=2,rgb=6'b11_01_10) and (x=5,y=10,rgb=6'b00_11_01), SWAP_REQ, FRAME_START; read address 2 column 5 -> RD_RGB_0=6'b110110, RD_RGB_1=6'b001101; SWAP_DONE pulses exactly once.
- Same writes but no FRAME_START after SWAP_REQ -> reads still return the old front contents (0), WR_READY stays 0, BUSY=1 indefinitely.
- CLEAR and SWAP_REQ asserted in the same cycle -> 256-cycle clear, then S_IDLE; a subsequent FRAME_START produces no SWAP_DONE and the front bank is unchanged.
- RD_EN held together with the swapping FRAME_START, RD_EN continued on the next cycle -> first read returns old-bank data, second returns new-bank data.
- Assert RESET_N=0 at clear count 100 -> all outputs return to their reset values immediately; after release WR_READY=1, front=0, a new CLEAR completes in 256 cycles.

Source files
------------

// File: rtl/led_framebuffer_pkg.sv
// rtl/led_framebuffer_pkg.sv - shared panel geometry, colour layout and FSM state type
// Purpose : panel geometry, default colour depth, {b,g,r} field offsets
//           (shared with the scan driver) and the framebuffer state encoding.
// Ports   : none (package).
package led_framebuffer_pkg;

   localparam int PANEL_COLUMNS       = 32;
   localparam int PANEL_ADDRESSES     = 8;
   localparam int PANEL_ROWS          = 16;
   localparam int DEFAULT_COLOR_DEPTH = 2;

   // Pixel word layout is {b,g,r}, each channel COLOR_DEPTH wide.
   localparam int R_LSB = 0;
   localparam int G_LSB = DEFAULT_COLOR_DEPTH;
   localparam int B_LSB = 2 * DEFAULT_COLOR_DEPTH;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_CLEAR     = 2'd1,
      S_SWAP_WAIT = 2'd2
   } fb_state_e;

   function automatic logic [3*DEFAULT_COLOR_DEPTH-1:0] pack_rgb(
      input logic [DEFAULT_COLOR_DEPTH-1:0] r,
      input logic [DEFAULT_COLOR_DEPTH-1:0] g,
      input logic [DEFAULT_COLOR_DEPTH-1:0] b);
      logic [3*DEFAULT_COLOR_DEPTH-1:0] w;
      w = '0;
      w[R_LSB +: DEFAULT_COLOR_DEPTH] = r;
      w[G_LSB +: DEFAULT_COLOR_DEPTH] = g;
      w[B_LSB +: DEFAULT_COLOR_DEPTH] = b;
      return w;
   endfunction

endpackage

// File: rtl/led_framebuffer_if.sv
// rtl/led_framebuffer_if.sv - producer, control and scan-read signals of the framebuffer
// Purpose : bundles the pixel write handshake, CLEAR/SWAP control, and the
//           scan driver read port.
// Modports: master = producer + scan driver side, slave = framebuffer side.
interface led_framebuffer_if #(
   parameter int COLOR_DEPTH  = 2,
   parameter int COLUMNS_BITS = 5,
   parameter int ADDRESS_BITS = 3
);
   logic                      WR_VALID;
   logic                      WR_READY;
   logic [COLUMNS_BITS-1:0]   WR_X;
   logic [ADDRESS_BITS:0]     WR_Y;
   logic [3*COLOR_DEPTH-1:0]  WR_RGB;
   logic                      CLEAR;
   logic                      SWAP_REQ;
   logic                      SWAP_DONE;
   logic                      FRAME_START;
   logic                      RD_EN;
   logic [ADDRESS_BITS-1:0]   RD_ADDRESS;
   logic [COLUMNS_BITS-1:0]   RD_COLUMN;
   logic                      RD_VALID;
   logic [3*COLOR_DEPTH-1:0]  RD_RGB_0;
   logic [3*COLOR_DEPTH-1:0]  RD_RGB_1;
   logic                      BUSY;

   modport master (
      output WR_VALID, WR_X, WR_Y, WR_RGB, CLEAR, SWAP_REQ, FRAME_START,
             RD_EN, RD_ADDRESS, RD_COLUMN,
      input  WR_READY, SWAP_DONE, RD_VALID, RD_RGB_0, RD_RGB_1, BUSY
   );

   modport slave (
      input  WR_VALID, WR_X, WR_Y, WR_RGB, CLEAR, SWAP_REQ, FRAME_START,
             RD_EN, RD_ADDRESS, RD_COLUMN,
      output WR_READY, SWAP_DONE, RD_VALID, RD_RGB_0, RD_RGB_1, BUSY
   );
endinterface

// File: rtl/led_framebuffer_ram.sv
// rtl/led_framebuffer_ram.sv - simple dual-port RAM with registered read port
// Purpose : one write port, one registered read port; no reset on storage or
//           read register so it maps onto iCE40 block RAM.
// Ports   : clk_i; we_i/waddr_i/wdata_i write port; re_i/raddr_i read enable
//           and address; rdata_o read data one cycle after re_i, held otherwise.
module led_framebuffer_ram #(
   parameter int DEPTH_BITS = 9,
   parameter int WIDTH      = 6
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_BITS-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_BITS-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);
   logic [WIDTH-1:0] mem [0:(1<<DEPTH_BITS)-1];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/led_framebuffer.sv
// rtl/led_framebuffer.sv - double-buffered 16x32 LED panel pixel store
// Purpose : producer writes pixels to the back bank; scan driver reads the
//           front bank top/bottom halves together; bank swap deferred to
//           FRAME_START; CLEAR zeroes the back bank.
// Ports   : CLOCK, RESET_N (async active-low); bus = led_framebuffer_if.slave
//           carrying write handshake, CLEAR/SWAP control and the read port.
module led_framebuffer
   import led_framebuffer_pkg::*;
#(
   parameter int COLOR_DEPTH  = DEFAULT_COLOR_DEPTH,
   parameter int COLUMNS_BITS = 5,
   parameter int ADDRESS_BITS = 3
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   led_framebuffer_if.slave  bus
);
   localparam int PW = 3 * COLOR_DEPTH;
   localparam int CW = ADDRESS_BITS + COLUMNS_BITS;
   localparam int AW = CW + 1;

   fb_state_e      state_q;
   logic           front_q;
   logic [CW-1:0]  clr_cnt_q;
   logic           swap_done_q;
   logic           rd_valid_q;
   logic           rd_seen_q;

   logic           clearing;
   logic           wr_ready;
   logic           wr_fire;
   logic           we_top_d;
   logic           we_bot_d;
   logic [AW-1:0]  waddr_d;
   logic [PW-1:0]  wdata_d;
   logic [AW-1:0]  raddr;
   logic [PW-1:0]  rdata_top;
   logic [PW-1:0]  rdata_bot;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         front_q     <= 1'b0;
         clr_cnt_q   <= '0;
         swap_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_seen_q   <= 1'b0;
      end else begin
         swap_done_q <= 1'b0;
         rd_valid_q  <= bus.RD_EN;
         if (bus.RD_EN) rd_seen_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               // CLEAR has priority; a simultaneous SWAP_REQ is dropped.
               if (bus.CLEAR) begin
                  state_q   <= S_CLEAR;
                  clr_cnt_q <= '0;
               end else if (bus.SWAP_REQ) begin
                  state_q <= S_SWAP_WAIT;
               end
            end
            S_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (&clr_cnt_q) state_q <= S_IDLE;
            end
            S_SWAP_WAIT: begin
               if (bus.FRAME_START) begin
                  front_q     <= ~front_q;
                  swap_done_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign clearing = (state_q == S_CLEAR);
   // The request-cycle CLEAR/SWAP_REQ also drops ready so no write can slip
   // in the cycle the FSM leaves idle.
   assign wr_ready = (state_q == S_IDLE) & ~bus.CLEAR & ~bus.SWAP_REQ;
   assign wr_fire  = bus.WR_VALID & wr_ready;

   // Both halves share one write address; WR_Y MSB picks the RAM.
   assign we_top_d = clearing | (wr_fire & ~bus.WR_Y[ADDRESS_BITS]);
   assign we_bot_d = clearing | (wr_fire &  bus.WR_Y[ADDRESS_BITS]);
   assign waddr_d  = clearing ? {~front_q, clr_cnt_q}
                              : {~front_q, bus.WR_Y[ADDRESS_BITS-1:0], bus.WR_X};
   assign wdata_d  = clearing ? '0 : bus.WR_RGB;
   assign raddr    = {front_q, bus.RD_ADDRESS, bus.RD_COLUMN};

   led_framebuffer_ram #(.DEPTH_BITS(AW), .WIDTH(PW)) u_ram_top (
      .clk_i   (CLOCK),
      .we_i    (we_top_d),
      .waddr_i (waddr_d),
      .wdata_i (wdata_d),
      .re_i    (bus.RD_EN),
      .raddr_i (raddr),
      .rdata_o (rdata_top)
   );

   led_framebuffer_ram #(.DEPTH_BITS(AW), .WIDTH(PW)) u_ram_bot (
      .clk_i   (CLOCK),
      .we_i    (we_bot_d),
      .waddr_i (waddr_d),
      .wdata_i (wdata_d),
      .re_i    (bus.RD_EN),
      .raddr_i (raddr),
      .rdata_o (rdata_bot)
   );

   // RAM read registers are not reset; masking until the first read gives
   // zero pixel outputs out of reset while still holding between reads.
   assign bus.RD_RGB_0  = rd_seen_q ? rdata_top : '0;
   assign bus.RD_RGB_1  = rd_seen_q ? rdata_bot : '0;
   assign bus.RD_VALID  = rd_valid_q;
   assign bus.SWAP_DONE = swap_done_q;
   assign bus.WR_READY  = wr_ready;
   assign bus.BUSY      = (state_q != S_IDLE);
endmodule
